// File: rtl/rom_stream_reader.sv
// rom_stream_reader: read master for a synchronous single-port ROM.
// On start it walks `length` consecutive addresses from `base_addr`, wrapping
// modulo DEPTH, and delivers each word on a valid/ready stream at up to one
// word per cycle. A 2-entry FIFO absorbs ROM data while the consumer stalls.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_a,
  input  logic [DATA_WIDTH-1:0] rom_do,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] last_a_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         accepted_q;
  logic                  inflight_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_beat;
  logic                  start_idle;

  assign m_valid    = (count_q != 2'd0);
  assign pop        = m_valid & m_ready;
  assign push       = inflight_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign start_idle = (state_q == IDLE) && start;
  assign last_beat  = (state_q == RUN) && pop && (accepted_q == len_q - CW'(1));
  assign m_data     = m_valid ? fifo_mem[rd_ptr_q] : '0;

  // Issue decision, ROM address and next state.
  // The read request is decided from registered occupancy in the same cycle
  // it is presented, so a word popped this cycle frees its slot immediately;
  // that is what lets a 2-entry FIFO sustain one word per cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    issue   = 1'b0;
    rom_a   = last_a_q;
    if (state_q == RUN) begin
      issue = (issued_q < len_q) &&
              (((count_q + 2'(inflight_q)) < 2'd2) || pop);
    end
    if (issue) begin
      rom_a = base_q + issued_q[ADDR_WIDTH-1:0];
    end
    case (state_q)
      IDLE:    if (start && (length != '0)) state_d = RUN;
      RUN:     if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_en = issue;

  // Control state: FSM, burst parameters, counters, read tracking, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      last_a_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= (start_idle && (length == '0)) || last_beat;
      if (issue) last_a_q <= rom_a;
      if (start_idle) begin
        base_q     <= base_addr;
        len_q      <= length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) issued_q   <= issued_q + CW'(1);
        if (pop)   accepted_q <= accepted_q + CW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; push is the ROM word returning a cycle after rom_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage captures rom_do on each push.
  // NOTE: the storage is not reset; m_data is gated by m_valid, so stale
  // contents after reset are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rom_do;
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: a ROM model with word[i]=i*0x1111,
// directed bursts (full sweep, wrap, stalls, zero length, ignored restart,
// mid-burst reset) and 100 randomised bursts against a queue scoreboard.
module tb_rom_stream_reader;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, rom_en, m_valid;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_do, m_data;
  logic          m_ready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] data_q[$];
  logic [AW-1:0] addr_q[$];
  int            exp_done = 0;
  int            done_seen = 0;
  int            acc_total = 0;
  int            outstanding = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit            ready_rand = 1'b0;
  bit            ready_force = 1'b1;

  rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_a     (rom_a),
    .rom_do    (rom_do),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: registered output, one-cycle read latency.
  always @(posedge clk) begin
    if (rom_en) rom_do <= rom[rom_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    32'(busy),    0);
    check({tag, "_done"},    32'(done),    0);
    check({tag, "_rom_en"},  32'(rom_en),  0);
    check({tag, "_rom_a"},   32'(rom_a),   0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_data"},  32'(m_data),  0);
  endtask

  // Pulse start for one cycle; when the burst should be accepted, queue the
  // addresses and words it must produce. Returns at the start of cycle 1.
  task automatic do_start(input int b, input int l, input bit accept);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    if (accept) begin
      for (int i = 0; i < l; i++) begin
        addr_q.push_back(AW'((b + i) % DEPTH));
        data_q.push_back(DW'(((b + i) % DEPTH) * 32'h1111));
      end
      exp_done++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_seen != exp_done && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check("burst_done", 32'(done_seen), 32'(exp_done));
    check("sb_drain",   32'(data_q.size()), 0);
    @(negedge clk);
  endtask

  // Consumer: ready is either forced by the directed tests or randomised.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: scoreboard pops, credit bound, head stability, done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 1);
          check("hold_data",  32'(m_data),  32'(prev_data));
        end
        if (rom_en) begin
          if (addr_q.size() == 0) check("unexpected_read_qdepth", 0, 1);
          else check("rom_a", 32'(rom_a), 32'(addr_q.pop_front()));
        end
        if (m_valid && m_ready) begin
          acc_total++;
          if (data_q.size() == 0) check("unexpected_beat_qdepth", 0, 1);
          else check("m_data", 32'(m_data), 32'(data_q.pop_front()));
        end
        outstanding += int'(rom_en) - int'(m_valid && m_ready);
        if (rom_en) check("credit_le_2", 32'(outstanding <= 2), 1);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
          done_seen++;
          check("busy_at_done", 32'(busy), 0);
        end
      end
    end
  end

  initial begin
    int a0;
    int n;
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i * 32'h1111);

    // Reset state
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full sweep, exact latency and throughput
    ready_force = 1'b1;
    do_start(0, 16, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", c), 32'(m_valid), 32'(c >= 3 && c <= 18));
      check($sformatf("t1_done_c%0d", c),  32'(done),    32'(c == 19));
      check($sformatf("t1_busy_c%0d", c),  32'(busy),    32'(c <= 18));
    end
    wait_done(50);

    // T2: wrap around the top of the address space
    do_start(14, 4, 1'b1);
    wait_done(50);

    // T3: consumer stalls in cycles 3..6
    do_start(0, 3, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        check($sformatf("t3_valid_c%0d", c), 32'(m_valid), 1);
        check($sformatf("t3_data_c%0d", c),  32'(m_data),  0);
      end
      ready_force = !((c + 1) >= 3 && (c + 1) <= 6);
    end
    ready_force = 1'b1;
    wait_done(50);

    // T4: zero-length burst
    do_start(7, 0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t4_done_c%0d", c),   32'(done),    32'(c == 1));
      check($sformatf("t4_busy_c%0d", c),   32'(busy),    0);
      check($sformatf("t4_rom_en_c%0d", c), 32'(rom_en),  0);
      check($sformatf("t4_valid_c%0d", c),  32'(m_valid), 0);
    end
    wait_done(10);

    // T5: a second start while busy is ignored
    do_start(3, 6, 1'b1);
    repeat (2) @(negedge clk);
    do_start(0, 2, 1'b0);
    wait_done(50);

    // T6: reset after two beats abandons the burst
    a0 = acc_total;
    do_start(5, 10, 1'b1);
    n = 0;
    while (acc_total < a0 + 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_two_beats", 32'(acc_total - a0), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    data_q.delete();
    addr_q.delete();
    exp_done--;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(9, 3, 1'b1);
    wait_done(50);

    // Randomised bursts with random back-pressure
    ready_rand = 1'b1;
    for (int k = 0; k < 100; k++) begin
      do_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 1'b1);
      wait_done(400);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ready_rand = 1'b0;
    repeat (3) @(negedge clk);

    check("done_count",   32'(done_seen), 32'(exp_done));
    check("addr_q_empty", 32'(addr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
